// File: rtl/cpu_supervisor.sv
// cpu_supervisor: host-side run controller for the CSM cpu core.
// Sequences the core's run request after a start-up delay, waits for the
// running acknowledge, counts run cycles and latches the pass/fail verdict.
// Optional feature macro: SUP_WATCHDOG_EN adds a START+RUN watchdog abort.
module cpu_supervisor #(
  parameter int unsigned STARTUP_DELAY  = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic             o_run,
  input  logic             i_running,
  input  logic             i_status,
  output logic             o_done,
  output logic             o_passed,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_cycles
);

  // A zero start-up delay is treated as a single cycle.
  localparam int unsigned DLY_LAST = (STARTUP_DELAY == 0) ? 0 : STARTUP_DELAY - 1;
  localparam logic [CNT_W-1:0] CYC_MAX = '1;

  typedef enum logic [1:0] {
    ST_DELAY = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] dly_cnt;
  logic             wd_expired;

`ifdef SUP_WATCHDOG_EN
  // Watchdog counter is widened if needed so the terminal count is always reachable.
  localparam int unsigned WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WD_W    = (WD_BITS > CNT_W) ? WD_BITS : CNT_W;
  localparam int unsigned WD_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  logic [WD_W-1:0] wd_cnt;

  // Count cycles spent in START+RUN; held at zero elsewhere so START entry sees 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd_cnt <= '0;
    end else if (state == ST_START || state == ST_RUN) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end else begin
      wd_cnt <= '0;
    end
  end

  assign wd_expired = (wd_cnt == WD_W'(WD_LAST));
`else
  logic unused_timeout_cfg;

  assign wd_expired         = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Run sequencer: state, delay counter and all registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_DELAY;
      dly_cnt   <= '0;
      o_run     <= 1'b0;
      o_done    <= 1'b0;
      o_passed  <= 1'b0;
      o_timeout <= 1'b0;
      o_cycles  <= '0;
    end else begin
      case (state)
        ST_DELAY: begin
          if (dly_cnt == CNT_W'(DLY_LAST)) begin
            state   <= ST_START;
            dly_cnt <= '0;
            o_run   <= 1'b1;
          end else begin
            dly_cnt <= dly_cnt + CNT_W'(1);
          end
        end
        ST_START: begin
          if (wd_expired) begin
            state     <= ST_DONE;
            o_run     <= 1'b0;
            o_done    <= 1'b1;
            o_passed  <= 1'b0;
            o_timeout <= 1'b1;
          end else if (i_running) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (o_cycles != CYC_MAX) begin
            o_cycles <= o_cycles + CNT_W'(1);
          end
          // A normal halt takes priority over a coincident watchdog expiry.
          if (!i_running) begin
            state     <= ST_DONE;
            o_run     <= 1'b0;
            o_done    <= 1'b1;
            o_passed  <= i_status;
            o_timeout <= 1'b0;
          end else if (wd_expired) begin
            state     <= ST_DONE;
            o_run     <= 1'b0;
            o_done    <= 1'b1;
            o_passed  <= 1'b0;
            o_timeout <= 1'b1;
          end
        end
        ST_DONE: begin
          if (i_start) begin
            state     <= ST_DELAY;
            dly_cnt   <= '0;
            o_done    <= 1'b0;
            o_passed  <= 1'b0;
            o_timeout <= 1'b0;
            o_cycles  <= '0;
          end
        end
        default: begin
          state   <= ST_DELAY;
          dly_cnt <= '0;
          o_run   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_supervisor.sv
// Testbench for cpu_supervisor: randomized core behaviour checked every cycle
// against a cycle-count model, plus literal checks of the key scenarios.
// Two instances share stimulus: a 16-bit counter and a 4-bit saturating one.
module tb_cpu_supervisor;

  localparam int unsigned DLY  = 3;
  localparam int unsigned TO   = 64;
  localparam int unsigned WS   = 4;
  localparam int          DEFF = (DLY == 0) ? 1 : int'(DLY);
`ifdef SUP_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic running = 1'b0;
  logic status = 1'b0;

  logic          run_a, done_a, pass_a, to_a;
  logic [15:0]   cyc_a;
  logic          run_b, done_b, pass_b, to_b;
  logic [WS-1:0] cyc_b;

  int n_checks = 0;
  int n_err    = 0;

  // Model state: what the outputs must be, tracked as counts of clock edges.
  int m_wait = 0;
  int m_cyc  = 0;
  int m_wd   = 0;
  bit m_run, m_acked, m_done, m_pass, m_to;

  always #5 clk = ~clk;

  cpu_supervisor #(.STARTUP_DELAY(DLY), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_run(run_a),
    .i_running(running), .i_status(status), .o_done(done_a),
    .o_passed(pass_a), .o_timeout(to_a), .o_cycles(cyc_a)
  );

  cpu_supervisor #(.STARTUP_DELAY(DLY), .TIMEOUT_CYCLES(TO), .CNT_W(WS)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_run(run_b),
    .i_running(running), .i_status(status), .o_done(done_b),
    .o_passed(pass_b), .o_timeout(to_b), .o_cycles(cyc_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out waiting at %0t", nm, $time);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_cyc = 0; m_wd = 0;
    m_run = 1'b0; m_acked = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_to = 1'b0;
  endtask

  // One clock edge of supervisor behaviour, written as phase rules on counts.
  task automatic model_step();
    if (m_done) begin
      if (start) begin
        m_done = 1'b0; m_pass = 1'b0; m_to = 1'b0; m_cyc = 0; m_wait = 0;
      end
    end else if (!m_run) begin
      m_wait++;
      if (m_wait >= DEFF) begin
        m_run = 1'b1; m_acked = 1'b0; m_wd = 0;
      end
    end else begin
      if (m_acked) m_cyc++;
      m_wd++;
      if (m_acked && !running) begin
        m_run = 1'b0; m_done = 1'b1; m_pass = status;
      end else if (WD_ON && m_wd >= int'(TO)) begin
        m_run = 1'b0; m_done = 1'b1; m_pass = 1'b0; m_to = 1'b1;
      end else if (running) begin
        m_acked = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Compare both instances against the model away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("run",     32'(run_a),  32'(m_run));
      chk("done",    32'(done_a), 32'(m_done));
      chk("passed",  32'(pass_a), 32'(m_pass));
      chk("timeout", 32'(to_a),   32'(m_to));
      chk("cycles",  32'(cyc_a),  32'(sat(m_cyc, 65535)));
      chk("run_s",   32'(run_b),  32'(m_run));
      chk("done_s",  32'(done_b), 32'(m_done));
      chk("passed_s", 32'(pass_b), 32'(m_pass));
      chk("timeout_s", 32'(to_b), 32'(m_to));
      chk("cycles_s", 32'(cyc_b), 32'(sat(m_cyc, (1 << WS) - 1)));
    end
  end

  task automatic wait_run(input string nm);
    int t = 0;
    while (!run_a && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!run_a) fail(nm);
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (!done_a && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!done_a) fail(nm);
  endtask

  // Behave as the cpu core: ack after lat cycles, stay running len cycles, halt with st.
  task automatic core_run(input int lat, input int len, input bit st, input bit poke);
    wait_run("core_wait_run");
    repeat (lat) @(negedge clk);
    running = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      status = 1'($urandom_range(0, 1));
      if (poke) start = 1'($urandom_range(0, 1));
    end
    start   = 1'b0;
    running = 1'b0;
    status  = st;
    @(negedge clk);
    wait_done("core_wait_done");
  endtask

  task automatic restart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_run", 32'(run_a), 32'd0);
    chk("rst_cycles", 32'(cyc_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("dly_run_low", 32'(run_a), 32'd0);
    @(negedge clk);
    chk("dly_run_high", 32'(run_a), 32'd1);

    // Passing run of 20 cycles
    core_run(1, 20, 1'b1, 1'b0);
    chk("t1_done", 32'(done_a), 32'd1);
    chk("t1_pass", 32'(pass_a), 32'd1);
    chk("t1_cycles", 32'(cyc_a), 32'd20);
    chk("t1_timeout", 32'(to_a), 32'd0);

    // Restart clears results on the same edge; o_run rises on the third edge after
    restart();
    chk("t2_clr_done", 32'(done_a), 32'd0);
    chk("t2_clr_cycles", 32'(cyc_a), 32'd0);
    chk("t2_clr_pass", 32'(pass_a), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t2_run_low", 32'(run_a), 32'd0);
    @(negedge clk);
    chk("t2_run_high", 32'(run_a), 32'd1);
    core_run(1, 20, 1'b0, 1'b1);
    chk("t2_done", 32'(done_a), 32'd1);
    chk("t2_pass", 32'(pass_a), 32'd0);
    chk("t2_cycles", 32'(cyc_a), 32'd20);
    chk("t2_run_off", 32'(run_a), 32'd0);

    // Long run saturates the narrow counter
    restart();
    core_run(0, 40, 1'b1, 1'b0);
    chk("t5_cycles_sat", 32'(cyc_b), 32'd15);
    chk("t5_cycles_wide", 32'(cyc_a), 32'd40);
    chk("t5_pass_sat", 32'(pass_b), 32'd1);

    // Randomized runs with spurious running in DONE and start pokes in RUN
    for (int k = 0; k < 10; k++) begin
      running = 1'b1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      running = 1'b0;
      restart();
      core_run(int'($urandom_range(0, 3)), int'($urandom_range(1, 50)),
               1'($urandom_range(0, 1)), 1'b1);
    end

    // Asynchronous reset in the middle of a run
    restart();
    wait_run("t6_wait_run");
    running = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_run_async", 32'(run_a), 32'd0);
    chk("t6_cycles_async", 32'(cyc_a), 32'd0);
    chk("t6_done_async", 32'(done_a), 32'd0);
    @(negedge clk);
    running = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    core_run(2, 10, 1'b1, 1'b1);
    chk("t6_cycles", 32'(cyc_a), 32'd10);
    chk("t6_pass", 32'(pass_a), 32'd1);

    // Core that never halts
    restart();
    wait_run("t4_wait_run");
    running = 1'b1;
    repeat (200) @(negedge clk);
`ifdef SUP_WATCHDOG_EN
    chk("t4_timeout", 32'(to_a), 32'd1);
    chk("t4_run_off", 32'(run_a), 32'd0);
`else
    chk("t4_run_held", 32'(run_a), 32'd1);
    chk("t4_no_done", 32'(done_a), 32'd0);
`endif
    running = 1'b0;
    @(negedge clk);
    wait_done("t4_wait_done");
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    fail("global_budget");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
